// File: rtl/timer_scheduler_pkg.sv
// Shared encodings for the timer scheduler: channel modes, channel FSM states
// and the channel-index width helper.
package timer_scheduler_pkg;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_RUN  = 1'b1;

   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/timer_scheduler_tick_divider.sv
// Prescaler for the timer scheduler: counts 0..CYCLES_PER_TICK-1 and raises tick
// for the single cycle in which the count sits at its maximum.
module tick_divider #(
   parameter int CYCLES_PER_TICK = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = $clog2(CYCLES_PER_TICK);
   localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES_PER_TICK - 1);

   logic [CW-1:0] r_cnt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign tick = (r_cnt == CNT_MAX);

endmodule

// File: rtl/timer_scheduler.sv
// Multi-channel tick timer: one-shot/periodic channels whose expirations are
// arbitrated round-robin onto a single registered valid/ready event port.
module timer_scheduler
   import timer_scheduler_pkg::*;
#(
   parameter int CYCLES_PER_TICK = 100_000_000,
   parameter int NUM_CH          = 4,
   parameter int CNT_W           = 16,
   localparam int CH_W           = ch_w(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_period,
   input  logic              cfg_mode,
   input  logic [NUM_CH-1:0] start,
   input  logic [NUM_CH-1:0] stop,
   output logic              tick,
   output logic [NUM_CH-1:0] busy,
   output logic [NUM_CH-1:0] overrun,
   output logic              evt_valid,
   output logic [CH_W-1:0]   evt_ch,
   input  logic              evt_ready
);

   logic              w_tick;
   logic [NUM_CH-1:0] w_pending;
   logic [NUM_CH-1:0] w_expire;
   logic [NUM_CH-1:0] w_take;
   logic [CNT_W-1:0]  w_cfg_period;
   logic              w_slot_free;
   logic              w_found;
   logic [CH_W-1:0]   w_pick;

   logic              r_valid;
   logic [CH_W-1:0]   r_ch;
   logic [CH_W-1:0]   r_rr;

   tick_divider #(
      .CYCLES_PER_TICK(CYCLES_PER_TICK)
   ) u_tick_divider (
      .clk (clk),
      .rst (rst),
      .tick(w_tick)
   );

   assign tick         = w_tick;
   assign w_cfg_period = (cfg_period == '0) ? CNT_W'(1) : cfg_period;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic             r_state;
      logic             r_mode;
      logic             r_pending;
      logic             r_overrun;
      logic [CNT_W-1:0] r_period;
      logic [CNT_W-1:0] r_remain;
      logic             w_cfg_hit;

      assign w_cfg_hit   = cfg_we && (cfg_ch == CH_W'(i));
      assign w_expire[i] = (r_state == ST_RUN) && w_tick && (r_remain == CNT_W'(1));

      always_ff @(posedge clk) begin
         if (rst) begin
            r_state   <= ST_IDLE;
            r_mode    <= MODE_ONESHOT;
            r_period  <= CNT_W'(1);
            r_remain  <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
         end else begin
            if (w_cfg_hit) begin
               r_period <= w_cfg_period;
               r_mode   <= cfg_mode;
            end
            // Stop overrides a same-cycle start entirely; an expiry is still recorded.
            if (stop[i]) begin
               r_state <= ST_IDLE;
            end else if (start[i]) begin
               r_state  <= ST_RUN;
               r_remain <= w_cfg_hit ? w_cfg_period : r_period;
            end else if (w_expire[i]) begin
               if (r_mode == MODE_PERIODIC) r_remain <= r_period;
               else                         r_state  <= ST_IDLE;
            end else if ((r_state == ST_RUN) && w_tick) begin
               r_remain <= r_remain - CNT_W'(1);
            end

            r_pending <= (r_pending && !w_take[i]) || w_expire[i];
            if (start[i] && !stop[i])                    r_overrun <= 1'b0;
            if (w_expire[i] && r_pending && !w_take[i]) r_overrun <= 1'b1;
         end
      end

      assign w_pending[i] = r_pending;
      assign busy[i]      = (r_state == ST_RUN);
      assign overrun[i]   = r_overrun;
   end

   // First pending channel at or after the round-robin pointer, with wrap-around.
   // NOTE: every always_comb output is defaulted up front so no latch is inferred.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         int j;
         j = int'(r_rr) + k;
         if (j >= NUM_CH) j = j - NUM_CH;
         if (!w_found && w_pending[CH_W'(j)]) begin
            w_found = 1'b1;
            w_pick  = CH_W'(j);
         end
      end
   end

   assign w_slot_free = !r_valid || evt_ready;
   assign w_take      = (w_slot_free && w_found) ? (NUM_CH'(1) << w_pick) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_ch    <= '0;
         r_rr    <= '0;
      end else if (w_slot_free) begin
         r_valid <= w_found;
         if (w_found) begin
            r_ch <= w_pick;
            r_rr <= (w_pick == CH_W'(NUM_CH - 1)) ? '0 : w_pick + CH_W'(1);
         end
      end
   end

   assign evt_valid = r_valid;
   assign evt_ch    = r_ch;

endmodule

// File: tb/tb_timer_scheduler.sv
// Bench for timer_scheduler: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural model of the channel/event rules.
module tb_timer_scheduler;

   localparam int CPT = 4;
   localparam int N   = 4;
   localparam int W   = 16;
   localparam int CHW = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic           cfg_we;
   logic [CHW-1:0] cfg_ch;
   logic [W-1:0]   cfg_period;
   logic           cfg_mode;
   logic [N-1:0]   start;
   logic [N-1:0]   stop;
   logic           tick;
   logic [N-1:0]   busy;
   logic [N-1:0]   overrun;
   logic           evt_valid;
   logic [CHW-1:0] evt_ch;
   logic           evt_ready;

   timer_scheduler #(
      .CYCLES_PER_TICK(CPT),
      .NUM_CH         (N),
      .CNT_W          (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we),
      .cfg_ch    (cfg_ch),
      .cfg_period(cfg_period),
      .cfg_mode  (cfg_mode),
      .start     (start),
      .stop      (stop),
      .tick      (tick),
      .busy      (busy),
      .overrun   (overrun),
      .evt_valid (evt_valid),
      .evt_ch    (evt_ch),
      .evt_ready (evt_ready)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Behavioural model
   int m_pc;
   bit m_run[N];
   int m_remain[N];
   int m_period[N];
   bit m_periodic[N];
   bit m_pend[N];
   bit m_ovr[N];
   bit m_valid;
   int m_ch;
   int m_rr;

   task automatic model_reset();
      m_pc = 0; m_valid = 0; m_ch = 0; m_rr = 0;
      for (int i = 0; i < N; i++) begin
         m_run[i] = 0; m_remain[i] = 0; m_period[i] = 1;
         m_periodic[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
      end
   endtask

   task automatic model_step();
      bit tk, free, found, ex, tk_ch;
      int pick, pe;
      if (rst) begin
         model_reset();
         return;
      end
      tk = (m_pc == CPT - 1);
      m_pc = (m_pc + 1) % CPT;
      free = !m_valid || evt_ready;
      found = 0; pick = 0;
      for (int k = 0; k < N; k++) begin
         int j = (m_rr + k) % N;
         if (!found && m_pend[j]) begin found = 1; pick = j; end
      end
      pe = (cfg_period == 0) ? 1 : int'(cfg_period);
      for (int i = 0; i < N; i++) begin
         ex    = m_run[i] && tk && (m_remain[i] == 1);
         tk_ch = free && found && (pick == i);
         if (start[i] && !stop[i])        m_ovr[i] = 0;
         if (ex && m_pend[i] && !tk_ch)   m_ovr[i] = 1;
         m_pend[i] = (m_pend[i] && !tk_ch) || ex;
         if (stop[i]) m_run[i] = 0;
         else if (start[i]) begin
            m_run[i] = 1;
            m_remain[i] = (cfg_we && int'(cfg_ch) == i) ? pe : m_period[i];
         end else if (ex) begin
            if (m_periodic[i]) m_remain[i] = m_period[i];
            else               m_run[i] = 0;
         end else if (m_run[i] && tk) m_remain[i]--;
      end
      if (cfg_we) begin
         m_period[cfg_ch]   = pe;
         m_periodic[cfg_ch] = cfg_mode;
      end
      if (free) begin
         m_valid = found;
         if (found) begin m_ch = pick; m_rr = (pick + 1) % N; end
      end
   endtask

   // Accepted-event log
   int             cyc;
   int             ev_n;
   int             ev_ch[$];
   int             ev_cyc[$];
   logic           s_valid;
   logic [CHW-1:0] s_ch;

   task automatic clear_ev();
      ev_n = 0; ev_ch.delete(); ev_cyc.delete();
   endtask

   task automatic step();
      logic [N-1:0] mb, mo;
      if (!rst && s_valid && evt_ready) begin
         ev_n++; ev_ch.push_back(int'(s_ch)); ev_cyc.push_back(cyc);
      end
      @(posedge clk);
      model_step();
      cyc++;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin mb[i] = m_run[i]; mo[i] = m_ovr[i]; end
      check("cyc_tick",    32'(tick),      32'(m_pc == CPT - 1));
      check("cyc_busy",    32'(busy),      32'(mb));
      check("cyc_overrun", 32'(overrun),   32'(mo));
      check("cyc_valid",   32'(evt_valid), 32'(m_valid));
      check("cyc_evt_ch",  32'(evt_ch),    32'(m_ch));
      s_valid = evt_valid;
      s_ch    = evt_ch;
   endtask

   task automatic idle_inputs();
      cfg_we = 0; cfg_ch = '0; cfg_period = '0; cfg_mode = 0; start = '0; stop = '0;
   endtask

   task automatic do_reset();
      rst = 1; step(); step(); rst = 0;
      cyc = 0;
   endtask

   task automatic cfg(input int ch, input int period, input bit mode);
      cfg_we = 1; cfg_ch = CHW'(ch); cfg_period = W'(period); cfg_mode = mode;
      step();
      cfg_we = 0;
   endtask

   task automatic start_ch(input logic [N-1:0] mask);
      start = mask; step(); start = '0;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic wait_ev(input int n, input int budget, input string tag);
      int b = 0;
      while (ev_n < n && b < budget) begin step(); b++; end
      check(tag, 32'(ev_n >= n), 32'(1));
   endtask

   initial begin
      rst = 1; evt_ready = 1; s_valid = 0; s_ch = '0; cyc = 0;
      idle_inputs();
      model_reset();
      clear_ev();

      // 1: reset state and tick cadence
      do_reset();
      check("rst_tick",    32'(tick),      32'(0));
      check("rst_busy",    32'(busy),      32'(0));
      check("rst_overrun", 32'(overrun),   32'(0));
      check("rst_valid",   32'(evt_valid), 32'(0));
      check("rst_evt_ch",  32'(evt_ch),    32'(0));
      for (int c = 1; c <= 11; c++) begin
         step();
         check($sformatf("tick_c%0d", c), 32'(tick), 32'((c % 4) == 3));
      end

      // 2: one-shot period 3 on ch0
      do_reset();
      cfg(0, 3, 0);
      clear_ev();
      start_ch(4'b0001);
      run(24);
      check("oneshot_count", 32'(ev_n), 32'(1));
      if (ev_n > 0) begin
         check("oneshot_ch",  32'(ev_ch[0]),  32'(0));
         check("oneshot_cyc", 32'(ev_cyc[0]), 32'(13));
      end
      check("oneshot_idle", 32'(busy), 32'(0));

      // 3: periodic period 2 on ch1, stop, then period 0 stored as 1
      do_reset();
      cfg(1, 2, 1);
      clear_ev();
      start_ch(4'b0010);
      run(40);
      check("per2_count", 32'(ev_n >= 3), 32'(1));
      if (ev_n >= 3) begin
         check("per2_gap1", 32'(ev_cyc[1] - ev_cyc[0]), 32'(8));
         check("per2_gap2", 32'(ev_cyc[2] - ev_cyc[1]), 32'(8));
         check("per2_ch",   32'(ev_ch[2]),               32'(1));
      end
      stop = 4'b0010; step(); stop = '0;
      run(4);
      clear_ev();
      run(20);
      check("stop_no_evt", 32'(ev_n), 32'(0));
      cfg(1, 0, 1);
      start_ch(4'b0010);
      run(6);
      clear_ev();
      run(20);
      check("per0_count", 32'(ev_n >= 3), 32'(1));
      if (ev_n >= 3) begin
         check("per0_gap1", 32'(ev_cyc[1] - ev_cyc[0]), 32'(4));
         check("per0_gap2", 32'(ev_cyc[2] - ev_cyc[1]), 32'(4));
      end

      // 4: all channels period 1, simultaneous start
      do_reset();
      for (int i = 0; i < N; i++) cfg(i, 1, 1);
      clear_ev();
      start_ch(4'b1111);
      run(10);
      check("all_count", 32'(ev_n >= 4), 32'(1));
      if (ev_n >= 4) begin
         for (int i = 0; i < 4; i++) begin
            check($sformatf("all_ch%0d", i),  32'(ev_ch[i]),              32'(i));
            check($sformatf("all_cyc%0d", i), 32'(ev_cyc[i] - ev_cyc[0]), 32'(i));
         end
      end
      do_reset();
      for (int i = 0; i < N; i++) cfg(i, 1, 1);
      evt_ready = 0;
      start_ch(4'b1111);
      begin
         int b = 0;
         while (overrun == '0 && b < 30) begin step(); b++; end
      end
      check("stall_overrun", 32'(overrun),   32'(4'b1110));
      check("stall_evt_ch",  32'(evt_ch),    32'(0));
      check("stall_valid",   32'(evt_valid), 32'(1));
      evt_ready = 1;

      // 5: round-robin resumes after the last accepted channel
      do_reset();
      cfg(2, 1, 0);
      cfg(0, 1, 0);
      cfg(3, 1, 0);
      clear_ev();
      start_ch(4'b0100);
      wait_ev(1, 20, "rr_first_timeout");
      if (ev_n > 0) check("rr_first_ch", 32'(ev_ch[0]), 32'(2));
      clear_ev();
      start_ch(4'b1001);
      wait_ev(2, 20, "rr_pair_timeout");
      if (ev_n >= 2) begin
         check("rr_pair0", 32'(ev_ch[0]), 32'(3));
         check("rr_pair1", 32'(ev_ch[1]), 32'(0));
      end

      // 6: reset while an event is held
      do_reset();
      cfg(1, 1, 1);
      evt_ready = 0;
      start_ch(4'b0010);
      begin
         int b = 0;
         while (!evt_valid && b < 20) begin step(); b++; end
      end
      check("midrst_valid_before", 32'(evt_valid), 32'(1));
      rst = 1; step(); rst = 0;
      check("midrst_valid",   32'(evt_valid), 32'(0));
      check("midrst_busy",    32'(busy),      32'(0));
      check("midrst_overrun", 32'(overrun),   32'(0));
      check("midrst_evt_ch",  32'(evt_ch),    32'(0));
      check("midrst_tick",    32'(tick),      32'(0));
      evt_ready = 1;
      clear_ev();
      run(12);
      check("midrst_no_evt", 32'(ev_n), 32'(0));

      // Randomized traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         idle_inputs();
         if ($urandom_range(0, 7) == 0) begin
            cfg_we     = 1;
            cfg_ch     = CHW'($urandom_range(0, N - 1));
            cfg_period = W'($urandom_range(0, 6));
            cfg_mode   = 1'($urandom_range(0, 1));
         end
         for (int i = 0; i < N; i++) begin
            start[i] = ($urandom_range(0, 15) == 0);
            stop[i]  = ($urandom_range(0, 39) == 0);
         end
         evt_ready = ($urandom_range(0, 9) < 7);
         rst = ($urandom_range(0, 499) == 0);
         step();
      end
      rst = 0;
      idle_inputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
